// File: rtl/spike_event_encoder.sv
// Turns the NEO detector's per-cycle spike flag into {timestamp, duration} events on a valid/ready stream.
// Optional build macro: SPIKE_ENC_DROP_CNT_EN adds the saturating dropped-event counter.
module spike_event_encoder #(
    parameter int TS_W       = 24,
    parameter int DUR_W      = 8,
    parameter int REFRACT    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spike_detected,
    output logic                          ev_valid,
    output logic [TS_W+DUR_W-1:0]         ev_data,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   dropped_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = TS_W + DUR_W;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;
    localparam logic [7:0]       RC_INIT = 8'(REFRACT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REFR   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [TS_W-1:0]   ts;
    logic [TS_W-1:0]   ts_start;
    logic [DUR_W-1:0]  dur;
    logic [7:0]        rcnt;
    logic              push;
    logic [EW-1:0]     push_data;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              full, empty, pop, wr_en, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + TS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (spike_detected) state_nxt = ACTIVE;
            ACTIVE:  if (!spike_detected) state_nxt = (REFRACT == 0) ? IDLE : REFR;
            REFR:    if (rcnt == 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The event is emitted on the first low sample after an active run.
    always_comb begin
        push      = (state == ACTIVE) && !spike_detected;
        push_data = {ts_start, dur};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_start <= '0;
            dur      <= '0;
            rcnt     <= '0;
        end else begin
            case (state)
                IDLE: if (spike_detected) begin
                    ts_start <= ts;
                    dur      <= DUR_W'(1);
                end
                ACTIVE: begin
                    if (spike_detected) begin
                        if (dur != DUR_MAX) dur <= dur + DUR_W'(1);
                    end else begin
                        rcnt <= RC_INIT;
                    end
                end
                REFR: if (rcnt != 8'd1) rcnt <= rcnt - 8'd1;
                default: ;
            endcase
        end
    end

    // Fullness is taken from the registered level, so a pop on the same edge cannot rescue a push.
    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign ev_valid   = !empty;
    assign pop        = ev_valid && ev_ready;
    assign wr_en      = push && !full;
    assign drop       = push && full;
    assign ev_data    = ev_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop)  overflow <= 1'b1;
        end
    end

`ifdef SPIKE_ENC_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
    end

    assign dropped_count = drop_cnt;
`else
    assign dropped_count = '0;
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed + randomized bench for spike_event_encoder, checked against an event-level reference model.
module tb_spike_event_encoder;

    localparam int TS_W  = 24;
    localparam int DUR_W = 8;
    localparam int RFR   = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spike_detected = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [31:0] ev_data;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] dropped_count;

    spike_event_encoder #(
        .TS_W(TS_W), .DUR_W(DUR_W), .REFRACT(RFR), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spike_detected(spike_detected),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
        .fifo_level(fifo_level), .overflow(overflow), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tcnt = 0;

    // Reference model: an event starts on a high sample at or after the arm time,
    // and the arm time is set to end-sample + 1 + refractory length.
    logic [31:0] mq[$];
    bit          m_in;
    int          m_start, m_len, m_arm, m_drop;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, tcnt, obs, exp);
        end
    endtask

    function automatic int exp_dc(input int n);
`ifdef SPIKE_ENC_DROP_CNT_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] ev(input int t, input int d);
        logic [23:0] tt;
        logic [7:0]  dd;
        tt = t[23:0];
        dd = (d > 255) ? 8'd255 : d[7:0];
        return {tt, dd};
    endfunction

    task automatic model_step(input logic s, input logic r);
        bit          full, do_pop, do_push;
        logic [31:0] e;
        full    = (mq.size() == DEPTH);
        do_pop  = (mq.size() != 0) && r;
        do_push = 1'b0;
        e       = '0;
        if (m_in) begin
            if (s) m_len++;
            else begin
                do_push = 1'b1;
                e       = ev(m_start, m_len);
                m_in    = 1'b0;
                m_arm   = tcnt + 1 + RFR;
            end
        end else if (s && tcnt >= m_arm) begin
            m_in    = 1'b1;
            m_start = tcnt;
            m_len   = 1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (full) begin
                m_ovf = 1'b1;
                m_drop++;
            end else mq.push_back(e);
        end
    endtask

    task automatic check_all();
        chk("ev_valid", ev_valid, mq.size() != 0);
        chk("ev_data", ev_data, (mq.size() != 0) ? mq[0] : 32'd0);
        chk("fifo_level", fifo_level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("dropped_count", dropped_count, exp_dc(m_drop));
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic cyc(input logic s, input logic r);
        spike_detected = s;
        ev_ready       = r;
        @(posedge clk);
        model_step(s, r);
        tcnt++;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        spike_detected = 1'b0;
        ev_ready       = 1'b0;
        #1;
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_data", ev_data, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dropped", dropped_count, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_in = 0; m_start = 0; m_len = 0; m_arm = 0; m_drop = 0; m_ovf = 0;
        tcnt = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    int  run_left;
    logic cur_s, cur_r;

    initial begin
        do_reset();

        // Basic event, then refractory suppression of the second spike
        for (int t = 0; t < 45; t++) begin
            cyc((t >= 10 && t <= 12) || (t >= 20 && t <= 35), 1'b1);
            if (t == 13) begin
                chk("t1_valid", ev_valid, 1);
                chk("t1_data", ev_data, {24'd10, 8'd3});
            end
            if (t == 14) begin
                chk("t1_valid_drop", ev_valid, 0);
                chk("t1_level", fifo_level, 0);
            end
            if (t == 36) chk("t2_data", ev_data, {24'd30, 8'd6});
        end

        // Long spike saturates duration without splitting
        do_reset();
        for (int t = 0; t < 320; t++) begin
            cyc(t >= 5 && t <= 304, 1'b0);
            if (t == 305) begin
                chk("t3_level", fifo_level, 1);
                chk("t3_data", ev_data, {24'd5, 8'd255});
            end
        end
        chk("t3_single", fifo_level, 1);
        for (int t = 0; t < 3; t++) cyc(1'b0, 1'b1);

        // Overflow with consumer stalled, then push+pop on a full FIFO
        do_reset();
        for (int t = 0; t < 200; t++) cyc((t % 20 == 2) || (t % 20 == 3), 1'b0);
        chk("t4_level", fifo_level, 8);
        chk("t4_overflow", overflow, 1);
        chk("t4_dropped", dropped_count, exp_dc(2));
        chk("t4_head", ev_data, {24'd2, 8'd2});
        for (int t = 200; t < 210; t++) begin
            cyc((t % 20 == 2) || (t % 20 == 3), t == 204);
            if (t == 204) begin
                chk("t5_level", fifo_level, 7);
                chk("t5_head", ev_data, {24'd22, 8'd2});
                chk("t5_dropped", dropped_count, exp_dc(3));
            end
        end

        // Asynchronous reset mid-ACTIVE with events queued
        do_reset();
        for (int t = 0; t < 66; t++) cyc((t % 20 == 2) || (t % 20 == 3) || t >= 60, 1'b0);
        chk("t6_queued", fifo_level, 3);
        do_reset();
        for (int t = 0; t < 10; t++) begin
            cyc(t == 4 || t == 5, 1'b0);
            if (t == 6) begin
                chk("t6_valid", ev_valid, 1);
                chk("t6_data", ev_data, {24'd4, 8'd2});
            end
        end

        // Randomized spikes and back-pressure
        do_reset();
        run_left = 0;
        cur_s    = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                cur_s = !cur_s;
                if (cur_s) run_left = ($urandom_range(0, 15) == 0) ? 280 : int'($urandom_range(1, 12));
                else       run_left = int'($urandom_range(1, 30));
            end
            run_left--;
            cur_r = (i % 800 < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            cyc(cur_s, cur_r);
            if (i == 2500) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
